// File: rtl/mat_loader.sv
// -----------------------------------------------------------------------------
// mat_loader
// Collects a stream of floating-point elements into two packed matrices for a
// downstream mat_mul. A frame is I*J elements of mat1 followed by J*K elements
// of mat2, each row-major; in_last must mark exactly the final element.
//
// Parameters:
//   I, J, K    : mat1 is I x J, mat2 is J x K
//   EXP_WIDTH  : float exponent width
//   MAN_WIDTH  : float mantissa width (element width FW = 1+EXP_WIDTH+MAN_WIDTH)
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   in_valid/in_ready   : element handshake, in_data/in_last carried with it
//   mat1, mat2          : packed matrices, element (r,c) at [(r*C+c)*FW +: FW]
//   out_valid/out_ready : matrix pair handshake; matrices stable while valid
//   frame_err           : one-cycle pulse when a frame is dropped for framing
//   nan_seen            : (only with MAT_LOADER_NAN_FLAG_EN) a NaN was accepted
//                         in the frame currently held
//
// Optional feature macro: MAT_LOADER_NAN_FLAG_EN
// -----------------------------------------------------------------------------
module mat_loader #(
  parameter int I         = 4,
  parameter int J         = 4,
  parameter int K         = 4,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]               in_data,
  input  logic                                       in_last,
  output logic [I*J*(1+EXP_WIDTH+MAN_WIDTH)-1:0]     mat1,
  output logic [J*K*(1+EXP_WIDTH+MAN_WIDTH)-1:0]     mat2,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       frame_err
`ifdef MAT_LOADER_NAN_FLAG_EN
  ,
  output logic                                       nan_seen
`endif
);

  localparam int FW    = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int NA    = I * J;
  localparam int NB    = J * K;
  localparam int NMAX  = (NA > NB) ? NA : NB;
  localparam int CW    = $clog2(NMAX + 1);

  localparam logic [CW-1:0] A_LAST = CW'(NA - 1);
  localparam logic [CW-1:0] B_LAST = CW'(NB - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             err_nxt_s;
  logic             frame_err_r;
  logic             accept_s;
  logic [NA*FW-1:0] mat1_r;
  logic [NB*FW-1:0] mat2_r;

  // Ready is withheld while the pair is held and during reset itself.
  assign in_ready  = !rst && (state_r != FULL);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == FULL);
  assign frame_err = frame_err_r;
  assign mat1      = mat1_r;
  assign mat2      = mat2_r;

  // Next-state, counter and framing-error decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (accept_s) begin
          if (in_last) begin
            // mat1 can never hold the final element of a frame
            err_nxt_s = 1'b1;
          end else if (cnt_r == A_LAST) begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = LOAD_B;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      LOAD_B: begin
        if (accept_s) begin
          if (cnt_r == B_LAST) begin
            if (in_last) begin
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = FULL;
            end else begin
              err_nxt_s = 1'b1;
            end
          end else if (in_last) begin
            err_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      FULL: begin
        if (out_ready) begin
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = LOAD_A;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = LOAD_A;
      end
    endcase
    // A framing error drops the whole frame
    if (err_nxt_s) begin
      cnt_nxt_s   = {CW{1'b0}};
      state_nxt_s = LOAD_A;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // State, counter and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD_A;
      cnt_r       <= {CW{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      frame_err_r <= err_nxt_s;
    end
  end

  // Matrix storage; the counter addresses the element slot directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat1_r <= {(NA*FW){1'b0}};
      mat2_r <= {(NB*FW){1'b0}};
    end else if (accept_s && (state_r == LOAD_A)) begin
      mat1_r[int'(cnt_r)*FW +: FW] <= in_data;
    end else if (accept_s && (state_r == LOAD_B)) begin
      mat2_r[int'(cnt_r)*FW +: FW] <= in_data;
    end else begin
      mat1_r <= mat1_r;
      mat2_r <= mat2_r;
    end
  end

`ifdef MAT_LOADER_NAN_FLAG_EN
  logic nan_r;
  logic nan_nxt_s;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [FW-1:0] d);
    is_nan = (&d[FW-2 -: EXP_WIDTH]) && (|d[MAN_WIDTH-1:0]);
  endfunction

  // Flag clears on (re)entry to LOAD_A, including a dropped frame.
  always_comb begin
    nan_nxt_s = nan_r;
    if (err_nxt_s || ((state_nxt_s == LOAD_A) && (state_r != LOAD_A))) begin
      nan_nxt_s = 1'b0;
    end else if (accept_s && is_nan(in_data)) begin
      nan_nxt_s = 1'b1;
    end else begin
      nan_nxt_s = nan_r;
    end
  end

  // NaN flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_r <= 1'b0;
    end else begin
      nan_r <= nan_nxt_s;
    end
  end

  assign nan_seen = nan_r;
`endif

endmodule

// File: tb/tb_mat_loader.sv
// -----------------------------------------------------------------------------
// tb_mat_loader
// Directed self-checking bench for mat_loader at default parameters
// (4x4 x 4x4, 32-bit floats). Inputs change 1 time unit after the rising edge
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mat_loader;

  localparam int FW = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [FW-1:0]   in_data;
  logic            in_last;
  logic [511:0]    mat1;
  logic [511:0]    mat2;
  logic            out_valid;
  logic            out_ready;
  logic            frame_err;
`ifdef MAT_LOADER_NAN_FLAG_EN
  logic            nan_seen;
`endif

  int passed;
  int total;

  logic [511:0] exp1;
  logic [511:0] exp2;

  mat_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mat1      (mat1),
    .mat2      (mat2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
`ifdef MAT_LOADER_NAN_FLAG_EN
    ,
    .nan_seen  (nan_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: 0x3F800000+n, mode 1: mode 0 with a NaN at word 5, mode 2: 0x40000000
  function automatic logic [31:0] word(input int mode, input int n);
    logic [31:0] d;
    d = 32'h3F80_0000 + 32'(n);
    if (mode == 1 && n == 5) d = 32'h7FC0_0000;
    if (mode == 2) d = 32'h4000_0000;
    return d;
  endfunction

  // Sends nwords words, in_last on word last_at, an idle cycle after every
  // gap-th word when gap>0; counts frame_err pulses and builds expected matrices.
  task automatic send_frame(input int mode, input int nwords, input int last_at,
                            input int gap, output int errs);
    errs = 0;
    for (int n = 0; n < nwords; n++) begin
      in_valid = 1'b1;
      in_data  = word(mode, n);
      in_last  = (n == last_at);
      if (n < 16) exp1[n*32 +: 32] = word(mode, n);
      else        exp2[(n-16)*32 +: 32] = word(mode, n);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (frame_err) errs++;
      if (gap > 0 && (n % gap) == gap - 1 && n != nwords - 1) begin
        tick();
        if (frame_err) errs++;
      end
    end
  endtask

  task automatic release_pair();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
    tick(); tick();
    total++; if (mat1 !== 512'd0 || mat2 !== 512'd0) $display("FAIL reset_mats got %h %h exp 0", mat1[31:0], mat2[31:0]); else passed++;
    total++; if (out_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL reset_outs got %b%b exp 00", out_valid, frame_err); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_full_frame();
    int errs;
    send_frame(0, 31, -1, 3, errs);
    total++; if (out_valid !== 1'b0) $display("FAIL full_early_valid got %b exp 0", out_valid); else passed++;
    send_frame_tail(0);
    total++; if (out_valid !== 1'b1) $display("FAIL full_out_valid got %b exp 1", out_valid); else passed++;
    total++; if (mat1[31:0] !== 32'h3F80_0000) $display("FAIL full_mat1_0 got %h exp 3f800000", mat1[31:0]); else passed++;
    total++; if (mat2[511:480] !== 32'h3F80_001F) $display("FAIL full_mat2_15 got %h exp 3f80001f", mat2[511:480]); else passed++;
    total++; if (mat1[511:480] !== 32'h3F80_000F) $display("FAIL full_mat1_15 got %h exp 3f80000f", mat1[511:480]); else passed++;
    total++; if (mat2[63:32] !== 32'h3F80_0011) $display("FAIL full_mat2_1 got %h exp 3f800011", mat2[63:32]); else passed++;
    total++; if (errs !== 0 || frame_err !== 1'b0) $display("FAIL full_no_err got %0d exp 0", errs); else passed++;
  endtask

  // Final word (n=31) of a frame with in_last set.
  task automatic send_frame_tail(input int mode);
    in_valid = 1'b1;
    in_data  = word(mode, 31);
    in_last  = 1'b1;
    exp2[511:480] = word(mode, 31);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    out_ready = 1'b0;
    // Offer a bogus element while full; it must not be taken
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || mat1 !== exp1 || mat2 !== exp2 || frame_err !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_before_release got %b exp 0", in_ready); else passed++;
    release_pair();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got valid %b ready %b exp 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_early_last();
    int errs;
    send_frame(0, 21, 20, 0, errs);
    total++; if (errs !== 1) $display("FAIL early_last_err got %0d exp 1", errs); else passed++;
    tick();
    total++; if (frame_err !== 1'b0 || out_valid !== 1'b0) $display("FAIL early_last_after got err %b valid %b exp 0 0", frame_err, out_valid); else passed++;
    send_frame(2, 31, -1, 0, errs);
    send_frame_tail(2);
    total++; if (out_valid !== 1'b1 || mat1 !== exp1 || mat2 !== exp2) $display("FAIL early_last_recover got valid %b mat1[31:0] %h exp 1 40000000", out_valid, mat1[31:0]); else passed++;
    release_pair();
  endtask

  task automatic test_missing_last();
    int errs;
    send_frame(0, 32, -1, 0, errs);
    total++; if (errs !== 1) $display("FAIL missing_last_err got %0d exp 1", errs); else passed++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL missing_last_state got valid %b ready %b exp 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_reset_midframe();
    int errs;
    int errs_rst;
    send_frame(0, 20, -1, 0, errs);
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL midrst_ready got %b exp 0", in_ready); else passed++;
    tick();
    errs_rst = frame_err ? 1 : 0;
    rst = 1'b0;
    #1;
    total++; if (mat1 !== 512'd0 || mat2 !== 512'd0 || out_valid !== 1'b0 || errs_rst !== 0) $display("FAIL midrst_outs got valid %b err %0d mat1[31:0] %h exp 0 0 0", out_valid, errs_rst, mat1[31:0]); else passed++;
    send_frame(0, 31, -1, 5, errs);
    send_frame_tail(0);
    total++; if (out_valid !== 1'b1 || mat1 !== exp1 || mat2 !== exp2 || errs !== 0) $display("FAIL midrst_newframe got valid %b errs %0d exp 1 0", out_valid, errs); else passed++;
    release_pair();
  endtask

`ifdef MAT_LOADER_NAN_FLAG_EN
  task automatic test_nan();
    int errs;
    send_frame(1, 31, -1, 0, errs);
    send_frame_tail(1);
    total++; if (out_valid !== 1'b1 || nan_seen !== 1'b1) $display("FAIL nan_set got valid %b nan %b exp 1 1", out_valid, nan_seen); else passed++;
    release_pair();
    total++; if (nan_seen !== 1'b0) $display("FAIL nan_clear_loada got %b exp 0", nan_seen); else passed++;
    send_frame(2, 31, -1, 0, errs);
    send_frame_tail(2);
    total++; if (out_valid !== 1'b1 || nan_seen !== 1'b0) $display("FAIL nan_clean_frame got valid %b nan %b exp 1 0", out_valid, nan_seen); else passed++;
    release_pair();
  endtask
`endif

  initial begin
    passed    = 0;
    total     = 0;
    exp1      = 512'd0;
    exp2      = 512'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_midframe();
`ifdef MAT_LOADER_NAN_FLAG_EN
    test_nan();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 The module SHALL have parameter I, default 4, giving the rows of mat1.
REQ-002 The module SHALL have parameter J, default 4, giving the mat1 columns and the mat2 rows.
REQ-003 The module SHALL have parameter K, default 4, giving the columns of mat2.
REQ-004 The module SHALL have parameter EXP_WIDTH, default 8, giving the float exponent width.
REQ-005 The module SHALL have parameter MAN_WIDTH, default 23, giving the float mantissa width. FW = 1+EXP_WIDTH+MAN_WIDTH.
REQ-006 The module SHALL have these ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  element offered.
- in_ready  output  1  element accepted when in_valid&&in_ready.
- in_data  input  FW  float element.
- in_last  input  1  marks the final element of a frame.
- mat1  output  I*J*FW  packed matrix for mat_mul.
- mat2  output  J*K*FW  packed matrix for mat_mul.
- out_valid  output  1  mat1/mat2 complete and stable.
- out_ready  input  1  consumer takes the pair.
- frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-007 A frame SHALL consist of I*J mat1 elements followed by J*K mat2 elements, each matrix in row-major order.
REQ-008 Element (r,c) of an R x C matrix SHALL occupy bits [(r*C+c)*FW +: FW].
REQ-009 The FSM SHALL have three states: LOAD_A, LOAD_B and FULL; it resets to LOAD_A.
REQ-010 LOAD_A SHALL write each accepted element into mat1 at the index given by the counter, then increment the counter.
REQ-011 On the I*J-th accepted element, LOAD_A SHALL clear the counter and move to LOAD_B.
REQ-012 LOAD_B SHALL write each accepted element into mat2 in the same way as LOAD_A.
REQ-013 On the J*K-th accepted element with in_last=1, LOAD_B SHALL move to FULL.
REQ-014 in_ready SHALL be 1 in LOAD_A and LOAD_B, and 0 in FULL.
REQ-015 out_valid SHALL equal (state==FULL), so it rises the cycle after the final element is accepted (latency 1).
REQ-016 In FULL, mat1 and mat2 SHALL hold stable until the cycle in which out_valid&&out_ready.
REQ-017 On out_valid&&out_ready the FSM SHALL move to LOAD_A with the counter at 0; in_ready rises the next cycle, so there is no same-cycle accept and release.
REQ-018 A framing error SHALL be an accepted element with in_last=1 that is not the final frame element, or the final element accepted with in_last=0.
REQ-019 On a framing error the block SHALL:
- pulse frame_err for one cycle;
- drop the frame and return to LOAD_A with the counter at 0;
- leave mat1/mat2 contents undefined until the next complete frame;
- keep out_valid at 0.
REQ-020 Counter width SHALL be clog2(max(I*J, J*K)+1) bits, and the counter SHALL never exceed the current matrix size minus 1.
REQ-021 in_valid=0 cycles between elements SHALL be tolerated with no effect on state.

Reset
REQ-022 rst is sampled on the rising clk edge only.
REQ-023 On reset the outputs SHALL be: state LOAD_A, counter 0, mat1=0, mat2=0, out_valid=0, frame_err=0, and nan_seen=0 when the macro is defined.
REQ-024 Reset asserted mid-frame or in FULL SHALL discard all data, with no frame_err pulse.
REQ-025 in_ready SHALL be 0 during any cycle in which rst=1.

Configuration
REQ-026 Macro MAT_LOADER_NAN_FLAG_EN, when defined, SHALL add the output port nan_seen (1 bit).
REQ-027 nan_seen SHALL be set when any accepted element has an all-ones exponent and a non-zero mantissa.
REQ-028 nan_seen SHALL be valid while out_valid is 1, and SHALL clear when the FSM enters LOAD_A.
REQ-029 When MAT_LOADER_NAN_FLAG_EN is undefined, the nan_seen port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Full frame (defaults): send 32 words 0x3F800000+n, n=0..31, with in_last on n=31 -> out_valid=1 one cycle later; mat1[31:0]=0x3F800000; mat2 bits [511:480]=0x3F80001F.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in FULL -> in_ready=0, and mat1/mat2/out_valid stay unchanged. Then assert out_ready=1 for 1 cycle -> LOAD_A, and in_ready=1 the next cycle.
REQ-032 Early last: set in_last on word 20 -> frame_err pulses once and out_valid stays 0. A following correct 32-word frame completes normally.
REQ-033 Missing last: send word 31 with in_last=0 -> frame_err=1 and no out_valid.
REQ-034 Reset in LOAD_B after 20 words -> outputs equal the REQ-023 reset values, and a new 32-word frame completes.
REQ-035 With MAT_LOADER_NAN_FLAG_EN defined, a frame containing 0x7FC00000 at word 5 -> nan_seen=1 with out_valid. A following all-0x40000000 frame -> nan_seen=0.
